aes_core_arbiter: RTL and testbench
===================================

# aes_core_arbiter

Shares one AES_top encryption core between two requester channels. Round-robin arbitration; holds the granted request's plaintext/key stable on the core while `AES_en` is high, captures the result on `AES_data_out_valid`, and returns it to the originating channel with a ready/valid response. A cycle timeout turns a silent core into an error response. Sits between the system-side request ports and the single AES_top instance.

## Interface

Parameters:
- `DATA_W`, 128, plaintext/key/ciphertext width
- `TIMEOUT`, 64, maximum `AES_en`-high cycles waiting for core valid (≥2)
- `GAP_CYCLES`, 2, cycles `AES_en` is held low between operations (≥1)

Ports:
- `AES_clk`  in  1  single clock, rising edge
- `AES_rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `req0_data` / `req1_data`  in  DATA_W  plaintext
- `req0_key` / `req1_key`  in  DATA_W  key
- `rsp0_valid` / `rsp1_valid`  out  1  response present
- `rsp0_ready` / `rsp1_ready`  in  1  response consumed
- `rsp0_data` / `rsp1_data`  out  DATA_W  ciphertext (0 on error)
- `rsp0_err` / `rsp1_err`  out  1  timeout flag
- `core_en`  out  1  drives AES_top `AES_en`
- `core_data_in`  out  DATA_W  drives `AES_data_in`
- `core_key_in`  out  DATA_W  drives `AES_key_in`
- `core_data_out`  in  DATA_W  from `AES_data_out`
- `core_data_out_valid`  in  1  from `AES_data_out_valid`
- `busy`  out  1  state ≠ IDLE
- `grant_id`  out  1  channel owning the core

## Operation

- States: IDLE, RUN, RESP, GAP.
- IDLE: pick winner among valid requests; `rr_ptr` has priority when both valid, otherwise the single requester wins. Winner's `reqN_ready` = 1 combinationally; loser's = 0. On handshake: latch data/key into `core_data_in`/`core_key_in`, set `grant_id`, `rr_ptr` ← ~winner, clear counter, → RUN.
- RUN: `core_en` = 1, data/key stable. Counter increments each cycle. On `core_data_out_valid`: latch `core_data_out`, err = 0, → RESP. Else at counter = TIMEOUT−1: data = 0, err = 1, → RESP. Valid and timeout in the same cycle: valid wins, err = 0.
- RESP: `core_en` = 0; `rsp<grant_id>_valid` = 1 with data/err stable until `rsp<grant_id>_ready`; on handshake → GAP. Other channel's rsp_valid stays 0.
- GAP: `core_en` = 0 for GAP_CYCLES cycles, then → IDLE. Both req_ready = 0.
- `core_data_out_valid` outside RUN is ignored.
- `req*_ready` = 0 in every state except IDLE.

## Timing

- Reset (async assert, sync-released by the clock domain): state IDLE, `rr_ptr` = 0, `grant_id` = 0, counter 0; all outputs 0 (`core_en`, `core_data_in`, `core_key_in`, `rsp*_valid`, `rsp*_data`, `rsp*_err`, `busy`). Reset mid-RUN drops `core_en` immediately; in-flight request lost, no response.
- Request handshake at edge t → `core_en` high from t+1.
- Core valid sampled at edge v → `rspN_valid` high from v+1 and `core_en` low from v+1.
- `rsp_ready` already high: response lasts one cycle; GAP follows; next `req_ready` earliest GAP_CYCLES+1 cycles after response handshake.
- Timeout: `core_en` high exactly TIMEOUT cycles, then error response.
- Minimum period per operation: 1 (accept) + core latency + 1 (RESP) + GAP_CYCLES.

## Structure

- Package `aes_ctrl_pkg`: state enum (IDLE/RUN/RESP/GAP), `AES_DATA_W = 128`, channel-id type (1 bit), default TIMEOUT/GAP constants.
- Sub-module `rr_arbiter2`: two-input round-robin, inputs valid0/valid1/ptr, outputs grant one-hot + id; purely combinational, pointer stays in the top FSM.
- Counter width `$clog2(TIMEOUT)`.

## Test plan

Bench uses a stub core: `data_out = data_in ^ key_in`, valid pulsed 10 cycles after `core_en` rises, unless disabled.
- Single req0, data 000000f0_00000000_00000000_00000000, key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc → `rsp0_data` = aa2bdbb0_bff6a5e8_caa9ba3e_bc1e2acc, err 0, `core_en` high 10 cycles then low ≥ GAP_CYCLES.
- req0 and req1 valid simultaneously from reset → req0 served first, then req1; then both again → req0 first (pointer alternated); no response routed to wrong channel.
- Stub valid disabled → `core_en` high exactly 64 cycles, `rsp*_err` = 1, data 0; next request then completes normally.
- `rsp0_ready` held low 5 cycles in RESP → rsp0_valid/data stable for all 5, `req*_ready` stays 0, `core_en` stays 0.
- Spurious `core_data_out_valid` in IDLE and GAP → no response, no state change; valid coinciding with timeout cycle → err 0, data captured.
- `AES_rst_n` asserted mid-RUN → all outputs 0 asynchronously; after release, first request serviced with `rr_ptr` = 0 priority.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES core arbiter.
// Imported by the arbiter top and its round-robin helper.
package aes_ctrl_pkg;

  localparam int AES_DATA_W  = 128;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_GAP     = 2;

  typedef logic chan_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESP,
    GAP
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin pick; the pointer lives in the caller.
// ptr_i names the channel that wins when both are valid.
module rr_arbiter2
  import aes_ctrl_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  chan_t      ptr_i,
  output logic [1:0] gnt_o,
  output chan_t      id_o
);

  // One-hot grant plus the winning channel id.
  always_comb begin
    gnt_o = 2'b00;
    id_o  = 1'b0;
    unique case (1'b1)
      (valid0_i && valid1_i): begin
        id_o  = ptr_i;
        gnt_o = ptr_i ? 2'b10 : 2'b01;
      end
      (valid0_i && !valid1_i): begin
        id_o  = 1'b0;
        gnt_o = 2'b01;
      end
      (valid1_i && !valid0_i): begin
        id_o  = 1'b1;
        gnt_o = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two request/response channels.
// Round-robin grant, timeout turns a silent core into an error.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int DATA_W     = AES_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int GAP_CYCLES = DEF_GAP
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req0_key,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req1_key,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic              core_en,
  output logic [DATA_W-1:0] core_data_in,
  output logic [DATA_W-1:0] core_key_in,
  input  logic [DATA_W-1:0] core_data_out,
  input  logic              core_data_out_valid,
  output logic              busy,
  output logic              grant_id
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  chan_t             rr_q, rr_d;
  chan_t             gid_q, gid_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;

  logic [1:0] gnt;
  chan_t      win_id;
  logic       rsp_hs;

  rr_arbiter2 u_arb (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .ptr_i    (rr_q),
    .gnt_o    (gnt),
    .id_o     (win_id)
  );

  assign rsp_hs = gid_q ? rsp1_ready : rsp0_ready;

  // Next-state, capture and request-ready decode.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    gid_d      = gid_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    din_d      = din_q;
    key_d      = key_q;
    res_d      = res_q;
    err_d      = err_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req0_ready = gnt[0];
        req1_ready = gnt[1];
        if (|gnt) begin
          din_d   = win_id ? req1_data : req0_data;
          key_d   = win_id ? req1_key : req0_key;
          gid_d   = win_id;
          rr_d    = ~win_id;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (core_data_out_valid) begin
          res_d   = core_data_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CLAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          gcnt_d  = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gcnt_q == GLAST) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      din_q   <= '0;
      key_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      din_q   <= din_d;
      key_q   <= key_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign core_en      = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign grant_id     = gid_q;
  assign core_data_in = din_q;
  assign core_key_in  = key_q;

  assign rsp0_valid = (state_q == RESP) && !gid_q;
  assign rsp1_valid = (state_q == RESP) && gid_q;
  assign rsp0_data  = rsp0_valid ? res_q : '0;
  assign rsp1_data  = rsp1_valid ? res_q : '0;
  assign rsp0_err   = rsp0_valid & err_q;
  assign rsp1_err   = rsp1_valid & err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter with an XOR stub core.
// Reference model tracks pending requests and round-robin pointer.
module tb_aes_core_arbiter;

  localparam int W   = 128;
  localparam int TO  = 64;
  localparam int GAP = 2;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp0_valid, rsp1_valid;
  logic         rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_err, rsp1_err;
  logic         core_en;
  logic [W-1:0] core_data_in, core_key_in, core_data_out;
  logic         core_data_out_valid;
  logic         busy, grant_id;

  logic         stub_en;
  logic         spur;
  int           en_cnt;

  int           n_cmp;
  int           n_bad;

  logic         pend_v [2];
  logic [W-1:0] pend_d [2];
  logic [W-1:0] pend_k [2];
  logic         ptr;
  logic [W-1:0] last_d;

  aes_core_arbiter #(
    .DATA_W     (W),
    .TIMEOUT    (TO),
    .GAP_CYCLES (GAP)
  ) dut (
    .AES_clk             (clk),
    .AES_rst_n           (rst_n),
    .req0_valid          (req0_valid),
    .req0_ready          (req0_ready),
    .req0_data           (req0_data),
    .req0_key            (req0_key),
    .req1_valid          (req1_valid),
    .req1_ready          (req1_ready),
    .req1_data           (req1_data),
    .req1_key            (req1_key),
    .rsp0_valid          (rsp0_valid),
    .rsp0_ready          (rsp0_ready),
    .rsp0_data           (rsp0_data),
    .rsp0_err            (rsp0_err),
    .rsp1_valid          (rsp1_valid),
    .rsp1_ready          (rsp1_ready),
    .rsp1_data           (rsp1_data),
    .rsp1_err            (rsp1_err),
    .core_en             (core_en),
    .core_data_in        (core_data_in),
    .core_key_in         (core_key_in),
    .core_data_out       (core_data_out),
    .core_data_out_valid (core_data_out_valid),
    .busy                (busy),
    .grant_id            (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub core: XOR result, valid in the 10th enabled cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_cnt <= 0;
    else if (!core_en) en_cnt <= 0;
    else en_cnt <= en_cnt + 1;
  end

  assign core_data_out = core_data_in ^ core_key_in;
  assign core_data_out_valid =
    (stub_en && core_en && en_cnt == 9) || spur;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic issue(input int ch,
                       input logic [W-1:0] d,
                       input logic [W-1:0] k);
    pend_v[ch] = 1'b1;
    pend_d[ch] = d;
    pend_k[ch] = k;
    if (ch == 1) begin
      req1_valid = 1'b1; req1_data = d; req1_key = k;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_key = k;
    end
  endtask

  // Serve the request the model says wins next, end to end.
  task automatic service(input int spur_at,
                         input int hold,
                         input bit spur_gap);
    int           ch, exp_en, en_cycles, w;
    logic [W-1:0] exp_d, held, sent_d;
    logic         exp_e;
    ch = (pend_v[0] && pend_v[1]) ? int'(ptr)
       : (pend_v[1] ? 1 : 0);
    if (stub_en) begin
      exp_d = pend_d[ch] ^ pend_k[ch]; exp_e = 0; exp_en = 10;
    end else if (spur_at > 0) begin
      exp_d = pend_d[ch] ^ pend_k[ch]; exp_e = 0; exp_en = spur_at;
    end else begin
      exp_d = '0; exp_e = 1; exp_en = TO;
    end
    sent_d = pend_d[ch];
    #1;
    w = 0;
    while (!(req0_ready || req1_ready) && w < 100) begin
      @(negedge clk); #1; w++;
    end
    chk("req_wait", W'(w < 100), W'(1));
    chk("grant_ch", W'(req1_ready), W'(ch[0]));
    chk("grant_excl", W'(req0_ready & req1_ready), '0);
    @(posedge clk);
    @(negedge clk);
    if (ch == 1) begin
      req1_valid = 1'b0; req1_data = rnd();
    end else begin
      req0_valid = 1'b0; req0_data = rnd();
    end
    pend_v[ch] = 1'b0;
    ptr = ~ch[0];
    #1;
    chk("grant_id", W'(grant_id), W'(ch[0]));
    chk("core_data_in", core_data_in, sent_d);
    en_cycles = 0;
    while (core_en && en_cycles < 300) begin
      en_cycles++;
      if (en_cycles == spur_at) spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
    end
    chk("en_cycles", W'(en_cycles), W'(exp_en));
    held = ch ? rsp1_data : rsp0_data;
    chk("rsp_valid", W'(ch ? rsp1_valid : rsp0_valid), W'(1));
    chk("rsp_other", W'(ch ? rsp0_valid : rsp1_valid), '0);
    chk("rsp_data", held, exp_d);
    chk("rsp_err", W'(ch ? rsp1_err : rsp0_err), W'(exp_e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", W'(ch ? rsp1_valid : rsp0_valid), W'(1));
      chk("hold_data", ch ? rsp1_data : rsp0_data, held);
      chk("hold_ready", W'(req0_ready | req1_ready), '0);
      chk("hold_en", W'(core_en), '0);
    end
    if (ch == 1) rsp1_ready = 1'b1;
    else rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    last_d = held;
    chk("rsp_drop", W'(rsp0_valid | rsp1_valid), '0);
    for (int g = 0; g < GAP; g++) begin
      if (spur_gap && g == 0) spur = 1'b1;
      #1;
      chk("gap_en", W'(core_en), '0);
      chk("gap_busy", W'(busy), W'(1));
      chk("gap_ready", W'(req0_ready | req1_ready), '0);
      chk("gap_rsp", W'(rsp0_valid | rsp1_valid), '0);
      @(negedge clk);
      spur = 1'b0;
    end
    chk("idle_after_gap", W'(busy), '0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_data = '0; req0_key = '0;
    req1_data = '0; req1_key = '0;
    rsp0_ready = 0; rsp1_ready = 0;
    stub_en = 1'b1; spur = 1'b0;
    pend_v[0] = 0; pend_v[1] = 0;
    ptr = 1'b0;
    last_d = '0;

    #1;
    chk("rst_core_en", W'(core_en), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_grant", W'(grant_id), '0);
    chk("rst_din", core_data_in, '0);
    chk("rst_key", core_key_in, '0);
    chk("rst_rsp", W'(rsp0_valid | rsp1_valid), '0);
    chk("rst_rsp_data", rsp0_data | rsp1_data, '0);
    chk("rst_rsp_err", W'(rsp0_err | rsp1_err), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both channels at once from reset, then again.
    issue(0, rnd(), rnd());
    issue(1, rnd(), rnd());
    service(0, 0, 0);
    service(0, 0, 0);
    issue(0, rnd(), rnd());
    issue(1, rnd(), rnd());
    service(0, 0, 0);
    service(0, 0, 0);

    // Known-answer single request on channel 0.
    issue(0, 128'h000000f0_00000000_00000000_00000000,
             128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc);
    service(0, 0, 0);
    chk("kat", last_d, 128'haa2bdbb0_bff6a5e8_caa9ba3e_bc1e2acc);

    // Silent core times out, next request completes.
    stub_en = 1'b0;
    issue(1, rnd(), rnd());
    service(0, 0, 0);
    stub_en = 1'b1;
    issue(1, rnd(), rnd());
    service(0, 0, 0);

    // Slow response consumer with the other channel waiting.
    issue(0, rnd(), rnd());
    issue(1, rnd(), rnd());
    service(0, 5, 0);
    service(0, 0, 0);

    // Spurious core valid in IDLE and in GAP.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_idle_busy", W'(busy), '0);
    chk("spur_idle_rsp", W'(rsp0_valid | rsp1_valid), '0);
    issue(0, rnd(), rnd());
    service(0, 0, 1);

    // Core valid lands on the timeout cycle.
    stub_en = 1'b0;
    issue(1, rnd(), rnd());
    service(TO, 0, 0);
    stub_en = 1'b1;

    // Random traffic patterns.
    for (int it = 0; it < 6; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      if (pat[0] && !pend_v[0]) issue(0, rnd(), rnd());
      if (pat[1] && !pend_v[1]) issue(1, rnd(), rnd());
      service(0, $urandom_range(0, 3), 0);
    end
    while (pend_v[0] || pend_v[1]) service(0, 0, 0);

    // Reset while running after a channel-0 grant.
    issue(0, rnd(), rnd());
    #1;
    for (int w = 0; w < 100 && !req0_ready; w++) begin
      @(negedge clk); #1;
    end
    chk("pre_rst_grant", W'(req0_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    pend_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("run_before_rst", W'(core_en), W'(1));
    rst_n = 1'b0;
    #1;
    ptr = 1'b0;
    chk("midrst_en", W'(core_en), '0);
    chk("midrst_busy", W'(busy), '0);
    chk("midrst_din", core_data_in, '0);
    chk("midrst_rsp", W'(rsp0_valid | rsp1_valid), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, rnd(), rnd());
    issue(1, rnd(), rnd());
    service(0, 0, 0);
    service(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
